// File: rtl/alu_pipe_elastic_if.sv
// Handshake bundle for alu_pipe_elastic: issue side (in_*) and result side (out_*).
interface alu_pipe_elastic_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned SH_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SH_W-1:0]  in_shamt;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;
  logic             out_sign;
  logic             out_illegal;

  // Producer of operations / consumer of results
  modport master (
    output in_valid, in_opcode, in_a, in_b, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_carry, out_ovf,
           out_zero, out_sign, out_illegal
  );

  // The ALU itself
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_carry, out_ovf,
           out_zero, out_sign, out_illegal
  );
endinterface

// File: rtl/alu_pipe_elastic.sv
// Two-stage elastic ALU: S1 captures the operation, S2 computes and holds the
// result until the consumer takes it. One op/cycle, in order, full back-pressure.
module alu_pipe_elastic #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input logic              clk,
  input logic              rst,
  alu_pipe_elastic_if.slave bus
);
  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned PW   = 2 * WIDTH;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_MULHU = 4'd3;
  localparam logic [3:0] OP_SLL   = 4'd4;
  localparam logic [3:0] OP_SRL   = 4'd5;
  localparam logic [3:0] OP_SRA   = 4'd6;
  localparam logic [3:0] OP_AND   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_XOR   = 4'd9;
  localparam logic [3:0] OP_NOR   = 4'd10;

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [SH_W-1:0]  s1_shamt;
  logic [TAG_W-1:0] s1_tag;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_carry_q;
  logic             out_ovf_q;
  logic             out_zero_q;
  logic             out_sign_q;
  logic             out_illegal_q;

  logic             s2_free;
  logic             in_ready_c;
  logic             in_fire;
  logic             s1_adv;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] c_res;
  logic             c_carry;
  logic             c_ovf;
  logic             c_ill;

  // S2 can take a new result when empty or being drained this cycle
  assign s2_free    = !out_valid_q || bus.out_ready;
  assign in_ready_c = !s1_valid || s2_free;
  assign in_fire    = bus.in_valid && in_ready_c;
  assign s1_adv     = s1_valid && s2_free;

  // S1 occupancy: refilled (or emptied) whenever it is allowed to move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready_c) begin
      s1_valid <= bus.in_valid;
    end
  end

  // S1 payload capture on an accepted operation
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op    <= bus.in_opcode;
      s1_a     <= bus.in_a;
      s1_b     <= bus.in_b;
      s1_shamt <= bus.in_shamt;
      s1_tag   <= bus.in_tag;
    end
  end

  // Execute the S1 operation
  always_comb begin
    sum     = {1'b0, s1_a} + {1'b0, s1_b};
    diff    = {1'b0, s1_a} - {1'b0, s1_b};
    prod    = PW'(s1_a) * PW'(s1_b);
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_ill   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        c_res   = sum[WIDTH-1:0];
        c_carry = sum[WIDTH];
        c_ovf   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        c_res   = diff[WIDTH-1:0];
        c_carry = diff[WIDTH];
        c_ovf   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_MUL:   c_res = prod[WIDTH-1:0];
      OP_MULHU: c_res = prod[PW-1:WIDTH];
      OP_SLL:   c_res = s1_a << s1_shamt;
      OP_SRL:   c_res = s1_a >> s1_shamt;
      OP_SRA:   c_res = $unsigned($signed(s1_a) >>> s1_shamt);
      OP_AND:   c_res = s1_a & s1_b;
      OP_OR:    c_res = s1_a | s1_b;
      OP_XOR:   c_res = s1_a ^ s1_b;
      OP_NOR:   c_res = ~(s1_a | s1_b);
      default:  c_ill = 1'b1;
    endcase
  end

  // S2 result register: loads when free, holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
      out_carry_q   <= 1'b0;
      out_ovf_q     <= 1'b0;
      out_zero_q    <= 1'b0;
      out_sign_q    <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      if (s2_free) begin
        out_valid_q <= s1_valid;
      end
      if (s1_adv) begin
        out_result_q  <= c_res;
        out_tag_q     <= s1_tag;
        out_carry_q   <= c_carry;
        out_ovf_q     <= c_ovf;
        out_zero_q    <= (c_res == '0);
        out_sign_q    <= c_res[WIDTH-1];
        out_illegal_q <= c_ill;
      end
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_carry   = out_carry_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.out_zero    = out_zero_q;
  assign bus.out_sign    = out_sign_q;
  assign bus.out_illegal = out_illegal_q;
endmodule
